// File: rtl/data_mem_responder_if.sv
// CPU data-bus and dump byte-stream signals of the accumulator CPU's data memory.
// master = CPU / debug consumer side, slave = data_mem_responder.
interface data_mem_responder_if #(
    parameter int ADDR_BITS  = 11,
    parameter int DATA_WIDTH = 16
);
    logic                  rd;
    logic                  wr;
    logic [ADDR_BITS-1:0]  addr_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  dump_start;
    logic                  dump_busy;
    logic                  dump_done;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output rd, wr, addr_data, out_data, dump_start, tx_ready,
        input  in_data, dump_busy, dump_done, tx_data, tx_valid
    );

    modport slave (
        input  rd, wr, addr_data, out_data, dump_start, tx_ready,
        output in_data, dump_busy, dump_done, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data RAM for the accumulator CPU with a byte-stream dump engine for the debug path.
// Optional access counters (rd_count/wr_count) are enabled by defining DATA_MEM_STATS_EN.
module data_mem_responder #(
    parameter int ADDR_BITS  = 11,
    parameter int DATA_WIDTH = 16,
    parameter int DUMP_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    data_mem_responder_if.slave    bus
`ifdef DATA_MEM_STATS_EN
    ,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
`endif
);
    localparam logic [ADDR_BITS-1:0] LAST_PTR = ADDR_BITS'(DUMP_DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HI, S_LO, S_DONE} state_e;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    state_e                state_q;
    logic [ADDR_BITS-1:0]  ptr_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic                  busy_q;
    logic                  done_q;

    // NOTE: the RAM array has no reset; clearing it would force flops instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (bus.wr) mem[bus.addr_data] <= bus.out_data;
    end

    // Read-before-write: a same-cycle write is not visible until after the edge.
    assign bus.in_data = bus.rd ? mem[bus.addr_data] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            word_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.dump_start) begin
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Snapshot through the second read port; later CPU writes do not affect this word.
                    word_q     <= mem[ptr_q];
                    tx_data_q  <= mem[ptr_q][15:8];
                    tx_valid_q <= 1'b1;
                    state_q    <= S_HI;
                end
                S_HI: begin
                    if (bus.tx_ready) begin
                        tx_data_q <= word_q[7:0];
                        state_q   <= S_LO;
                    end
                end
                S_LO: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                        if (ptr_q == LAST_PTR) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            ptr_q   <= ptr_q + ADDR_BITS'(1);
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.dump_busy = busy_q;
    assign bus.dump_done = done_q;

`ifdef DATA_MEM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    // NOTE: combinational blocks assign a default first so no path leaves a value held (no latch).
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (bus.rd && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        if (bus.wr && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif
endmodule
